// File: rtl/core_pkg.sv
// Shared backend configuration: data width, physical register count
// and default port counts for the multiport register file.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int PREGS      = 64;
    localparam int TAGW       = $clog2(PREGS);

    localparam int PRF_NWR    = 2;
    localparam int PRF_NRD    = 4;
    localparam int PRF_NALLOC = 2;

    typedef logic [TAGW-1:0] preg_tag_t;

endpackage

// File: rtl/prf_wr_arbiter.sv
// Write-port priority: lowest index wins per tag, tag 0 is masked.
// Also flags any two enabled ports hitting the same nonzero tag.
module prf_wr_arbiter #(
    parameter int NWR  = 2,
    parameter int TAGW = 6
) (
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][TAGW-1:0] wtag,
    output logic [NWR-1:0]           wen_eff,
    output logic                     conflict
);

    // Drop a port if a lower-index enabled port already owns its tag.
    always_comb begin
        wen_eff  = '0;
        conflict = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            wen_eff[i] = wen[i] && (wtag[i] != '0);
            for (int k = 0; k < i; k++) begin
                if (wen[k] && wen[i] && (wtag[k] == wtag[i])
                    && (wtag[i] != '0)) begin
                    wen_eff[i] = 1'b0;
                    conflict   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prf_multiport.sv
// Physical register file with ready scoreboard, NWR/NRD/NALLOC ports.
// Optional same-cycle write-to-read bypass under macro PRF_BYPASS_EN.
module prf_multiport
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int PREGS  = core_pkg::PREGS,
    parameter int NWR    = core_pkg::PRF_NWR,
    parameter int NRD    = core_pkg::PRF_NRD,
    parameter int NALLOC = core_pkg::PRF_NALLOC,
    localparam int TAGW  = $clog2(PREGS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NWR-1:0]              wen,
    input  logic [NWR-1:0][TAGW-1:0]    wtag,
    input  logic [NWR-1:0][XLEN-1:0]    wdata,
    input  logic [NALLOC-1:0]           alloc_en,
    input  logic [NALLOC-1:0][TAGW-1:0] alloc_tag,
    input  logic [NRD-1:0][TAGW-1:0]    rtag,
    output logic [NRD-1:0][XLEN-1:0]    rdata,
    output logic [NRD-1:0]              rready,
    output logic                        wr_conflict
);

    logic [XLEN-1:0]  regs_q [PREGS];
    logic [PREGS-1:0] ready_q;
    logic [PREGS-1:0] ready_d;
    logic             conflict_q;
    logic [NWR-1:0]   wen_eff;
    logic             conflict;

    prf_wr_arbiter #(
        .NWR  (NWR),
        .TAGW (TAGW)
    ) u_arb (
        .wen      (wen),
        .wtag     (wtag),
        .wen_eff  (wen_eff),
        .conflict (conflict)
    );

    // Data array: arbitrated writes, entry 0 never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < PREGS; e++) begin
                regs_q[e] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wen_eff[i]) begin
                    regs_q[wtag[i]] <= wdata[i];
                end
            end
        end
    end

    // Scoreboard next state: writeback sets, allocation clear wins.
    always_comb begin
        ready_d = ready_q;
        for (int i = 0; i < NWR; i++) begin
            if (wen_eff[i]) begin
                ready_d[wtag[i]] = 1'b1;
            end
        end
        for (int j = 0; j < NALLOC; j++) begin
            if (alloc_en[j] && (alloc_tag[j] != '0)) begin
                ready_d[alloc_tag[j]] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
    end

    // Scoreboard and conflict pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= '1;
            conflict_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            conflict_q <= conflict;
        end
    end

    assign wr_conflict = conflict_q;

    // Combinational read ports, tag 0 forced to zero/ready.
    always_comb begin
        rdata  = '0;
        rready = '0;
        for (int p = 0; p < NRD; p++) begin
            rdata[p]  = regs_q[rtag[p]];
            rready[p] = ready_q[rtag[p]];
`ifdef PRF_BYPASS_EN
            for (int i = NWR - 1; i >= 0; i--) begin
                if (wen_eff[i] && (wtag[i] == rtag[p])) begin
                    rdata[p]  = wdata[i];
                    rready[p] = 1'b1;
                end
            end
`endif
            if (rtag[p] == '0) begin
                rdata[p]  = '0;
                rready[p] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prf_multiport.sv
// Randomised and directed bench for prf_multiport against an
// array-based reference model of the register file and scoreboard.
module tb_prf_multiport;
    import core_pkg::*;

    localparam int W  = core_pkg::XLEN;
    localparam int PR = core_pkg::PREGS;
    localparam int NW = core_pkg::PRF_NWR;
    localparam int NR = core_pkg::PRF_NRD;
    localparam int NA = core_pkg::PRF_NALLOC;
    localparam int TW = $clog2(PR);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NW-1:0]           wen;
    logic [NW-1:0][TW-1:0]   wtag;
    logic [NW-1:0][W-1:0]    wdata;
    logic [NA-1:0]           alloc_en;
    logic [NA-1:0][TW-1:0]   alloc_tag;
    logic [NR-1:0][TW-1:0]   rtag;
    logic [NR-1:0][W-1:0]    rdata;
    logic [NR-1:0]           rready;
    logic                    wr_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mregs  [PR];
    bit           mready [PR];
    bit           exp_conf;

    prf_multiport dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wen         (wen),
        .wtag        (wtag),
        .wdata       (wdata),
        .alloc_en    (alloc_en),
        .alloc_tag   (alloc_tag),
        .rtag        (rtag),
        .rdata       (rdata),
        .rready      (rready),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < PR; e++) begin
            mregs[e]  = '0;
            mready[e] = 1'b1;
        end
        exp_conf = 1'b0;
    endtask

    // What a reader of tag t should see right now.
    task automatic exp_read(input logic [TW-1:0] t,
                            output logic [W-1:0] d, output bit r);
        d = mregs[t];
        r = mready[t];
`ifdef PRF_BYPASS_EN
        for (int i = NW - 1; i >= 0; i--) begin
            if (reset_n && wen[i] && wtag[i] == t) begin
                d = wdata[i];
                r = 1'b1;
            end
        end
`endif
        if (t == 0) begin
            d = '0;
            r = 1'b1;
        end
    endtask

    // Apply one clock edge of the reference rules.
    task automatic model_clk();
        bit taken [PR];
        int cnt   [PR];
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int e = 0; e < PR; e++) begin
            taken[e] = 1'b0;
            cnt[e]   = 0;
        end
        for (int i = 0; i < NW; i++) begin
            if (wen[i] && wtag[i] != 0) begin
                cnt[wtag[i]]++;
                if (!taken[wtag[i]]) begin
                    mregs[wtag[i]] = wdata[i];
                    taken[wtag[i]] = 1'b1;
                end
            end
        end
        exp_conf = 1'b0;
        for (int e = 1; e < PR; e++) begin
            if (taken[e]) mready[e] = 1'b1;
            if (cnt[e] > 1) exp_conf = 1'b1;
        end
        for (int j = 0; j < NA; j++) begin
            if (alloc_en[j] && alloc_tag[j] != 0) mready[alloc_tag[j]] = 1'b0;
        end
    endtask

    task automatic check_reads();
        logic [W-1:0] d;
        bit           r;
        for (int p = 0; p < NR; p++) begin
            exp_read(rtag[p], d, r);
            chk($sformatf("rdata%0d_t%0d", p, rtag[p]), 64'(rdata[p]), 64'(d));
            chk($sformatf("rready%0d_t%0d", p, rtag[p]), 64'(rready[p]), 64'(r));
        end
    endtask

    // Inputs are set at negedge; checks then one posedge.
    task automatic cycle();
        #1;
        chk("wr_conflict", 64'(wr_conflict), 64'(exp_conf));
        check_reads();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic idle();
        wen       = '0;
        wtag      = '0;
        wdata     = '0;
        alloc_en  = '0;
        alloc_tag = '0;
        for (int p = 0; p < NR; p++) rtag[p] = TW'($urandom_range(0, PR - 1));
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Post-reset view of tags 0, 5 and top entry.
        rtag[0] = TW'(0);
        rtag[1] = TW'(5);
        rtag[2] = TW'(PR - 1);
        rtag[3] = TW'(5);
        #1;
        for (int p = 0; p < NR; p++) begin
            chk("rst_rdata", 64'(rdata[p]), 64'd0);
            chk("rst_rready", 64'(rready[p]), 64'd1);
        end
        chk("rst_conflict", 64'(wr_conflict), 64'd0);
        cycle();

        // Write tag 7, same-cycle and next-cycle reads.
        wen[0] = 1'b1; wtag[0] = TW'(7); wdata[0] = 32'hDEADBEEF;
        rtag[0] = TW'(7);
        #1;
`ifdef PRF_BYPASS_EN
        chk("t7_same_cycle", 64'(rdata[0]), 64'hDEADBEEF);
`else
        chk("t7_same_cycle", 64'(rdata[0]), 64'd0);
`endif
        cycle();
        idle(); rtag[0] = TW'(7);
        #1;
        chk("t7_next_cycle", 64'(rdata[0]), 64'hDEADBEEF);
        cycle();

        // Both ports hit tag 9; port 0 wins, one-cycle pulse.
        wen = '1; wtag[0] = TW'(9); wtag[1] = TW'(9);
        wdata[0] = 32'h11; wdata[1] = 32'h22;
        cycle();
        idle(); rtag[0] = TW'(9);
        #1;
        chk("t9_conflict_pulse", 64'(wr_conflict), 64'd1);
        chk("t9_data", 64'(rdata[0]), 64'h11);
        cycle();
        wen = '1; wtag = '0; wdata[0] = 32'h33; wdata[1] = 32'h44;
        #1;
        chk("t9_pulse_end", 64'(wr_conflict), 64'd0);
        cycle();
        idle();
        #1;
        chk("t0_no_conflict", 64'(wr_conflict), 64'd0);
        cycle();

        // Scoreboard on tag 12.
        alloc_en[0] = 1'b1; alloc_tag[0] = TW'(12); rtag[0] = TW'(12);
        #1;
        chk("t12_alloc_cycle_rdy", 64'(rready[0]), 64'd1);
        cycle();
        idle(); rtag[0] = TW'(12);
        #1;
        chk("t12_after_alloc", 64'(rready[0]), 64'd0);
        wen[1] = 1'b1; wtag[1] = TW'(12); wdata[1] = 32'h55;
        cycle();
        idle(); rtag[0] = TW'(12);
        #1;
        chk("t12_wb_rdy", 64'(rready[0]), 64'd1);
        chk("t12_wb_data", 64'(rdata[0]), 64'h55);
        alloc_en[1] = 1'b1; alloc_tag[1] = TW'(12);
        wen[0] = 1'b1; wtag[0] = TW'(12); wdata[0] = 32'h77;
        cycle();
        idle(); rtag[0] = TW'(12);
        #1;
        chk("t12_both_rdy", 64'(rready[0]), 64'd0);
        chk("t12_both_data", 64'(rdata[0]), 64'h77);
        cycle();

        // Zero register ignores write and alloc.
        wen[0] = 1'b1; wtag[0] = '0; wdata[0] = 32'h1234;
        alloc_en[0] = 1'b1; alloc_tag[0] = '0;
        cycle();
        idle(); rtag[0] = '0;
        #1;
        chk("t0_data", 64'(rdata[0]), 64'd0);
        chk("t0_rdy", 64'(rready[0]), 64'd1);
        cycle();

        // Tag 3 written then allocated, then reset with a write in flight.
        wen[0] = 1'b1; wtag[0] = TW'(3); wdata[0] = 32'hAA;
        cycle();
        idle(); alloc_en[0] = 1'b1; alloc_tag[0] = TW'(3);
        cycle();
        idle();
        wen[0] = 1'b1; wtag[0] = TW'(3); wdata[0] = 32'hBB;
        reset_n = 1'b0;
        model_reset();
        cycle();
        reset_n = 1'b1;
        idle(); rtag[0] = TW'(3);
        #1;
        chk("t3_post_rst_data", 64'(rdata[0]), 64'd0);
        chk("t3_post_rst_rdy", 64'(rready[0]), 64'd1);
        cycle();

        // Random traffic concentrated on a few tags.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NW; i++) begin
                wen[i]   = ($urandom_range(0, 2) != 0);
                wtag[i]  = ($urandom_range(0, 7) == 0) ?
                           TW'($urandom_range(0, PR - 1)) :
                           TW'($urandom_range(0, 7));
                wdata[i] = $urandom;
            end
            for (int j = 0; j < NA; j++) begin
                alloc_en[j]  = ($urandom_range(0, 3) == 0);
                alloc_tag[j] = TW'($urandom_range(0, 7));
            end
            for (int p = 0; p < NR; p++) begin
                rtag[p] = ($urandom_range(0, 5) == 0) ?
                          TW'($urandom_range(0, PR - 1)) :
                          TW'($urandom_range(0, 7));
            end
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised physical register file with per-entry ready scoreboard, replacing the fixed 2-write/4-read PRF in the out-of-order backend.
- Sits between rename/dispatch and the execute/writeback stage.
- Provides NRD combinational read ports with a ready bit per port, and NWR write ports with fixed priority.
- Rename clears ready bits through NALLOC allocation ports; writeback sets them.
- Physical register 0 is wired-zero and always ready.

## Interface
Parameters:
- XLEN, core_pkg::XLEN, data width
- PREGS, core_pkg::PREGS, number of physical entries (≥ 2)
- NWR, 2, write (writeback) ports
- NRD, 4, read ports
- NALLOC, 2, rename allocation ports
- TAGW, $clog2(PREGS), tag width (derived; not overridden)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- wen  in  NWR  write enable per port
- wtag  in  NWR×TAGW  write tag per port
- wdata  in  NWR×XLEN  write data per port
- alloc_en  in  NALLOC  allocation valid per port
- alloc_tag  in  NALLOC×TAGW  newly allocated preg; its ready bit clears
- rtag  in  NRD×TAGW  read tag per port
- rdata  out  NRD×XLEN  read data per port
- rready  out  NRD  ready bit of rtag per port
- wr_conflict  out  1  registered one-cycle pulse: two enabled write ports targeted the same nonzero tag in the previous cycle

## Operation
Storage:
- regs[PREGS] data array.
- ready[PREGS] scoreboard.

Write:
- Each enabled port i writes regs[wtag[i]] at posedge.
- On a tag collision, the lowest-index port wins; higher ports are dropped for that tag.
- Writes to tag 0 are ignored.

Ready:
- Writeback on port i sets ready[wtag[i]].
- alloc_en[j] clears ready[alloc_tag[j]].
- Same tag allocated and written back in one cycle: the clear wins, so ready = 0.
- Allocation of tag 0 is ignored; ready[0] is constant 1.

Read (combinational per port):
- tag 0 returns rdata = 0 and rready = 1.
- Otherwise returns regs[rtag], ready[rtag], subject to bypass (see Configuration).

wr_conflict:
- Set at posedge if any pair i<k has wen[i] & wen[k] & wtag[i]==wtag[k] != 0.
- Otherwise 0.
- Diagnostic only; no effect on storage beyond the priority rule.

Allocation-port collision (two alloc ports, same tag): legal, idempotent clear.

## Timing
- Reset (async assert, sync-safe deassert): all regs = 0, all ready = 1, wr_conflict = 0.
- rdata and rready are combinational from rtag and the array state, so they follow reset immediately.
- Write to read latency:
  - 0 cycles with bypass compiled in.
  - 1 cycle (visible after the posedge) without it.
- Allocation: ready drops in the cycle after the alloc posedge. There is no same-cycle bypass of the clear, so dispatch sees the old value in the alloc cycle.
- Reset mid-operation discards in-flight writes and allocations; the first cycle after deassert behaves as post-reset.
- wr_conflict is high for exactly the one cycle following the conflicting cycle.

## Configuration
Macro PRF_BYPASS_EN.
- Defined: the read of tag t returns the wdata of the lowest-index enabled port writing t this cycle, with rready = 1. The bypass ignores an alloc of t in the same cycle.
- Undefined: reads return stored state only. Same-cycle writes appear the next cycle, and the read path contains no wdata muxing.

## Structure
- core_pkg holds:
  - XLEN, PREGS
  - preg_tag_t (TAGW bits)
  - PRF_NWR, PRF_NRD, PRF_NALLOC defaults
- Sub-module prf_wr_arbiter:
  - Inputs: wen/wtag.
  - Outputs: per-port effective write enables after the lowest-index priority and tag-0 masking, plus the conflict flag.
  - Reused by the array write logic and by the bypass mux.
- Storage is a flop array (no SRAM macro), synthesisable with reset.

## Test plan
- Reset: after reset_n deassert, read tags 0, 5 and PREGS-1 → rdata = 0 and rready = 1 on all ports; wr_conflict = 0.
- Write/read: write 0xDEADBEEF to tag 7 on port 0, then read tag 7 next cycle → 0xDEADBEEF. In the same cycle, with PRF_BYPASS_EN, the read also returns 0xDEADBEEF; without it, the read returns 0.
- Conflict: ports 0 and 1 write tag 9 with 0x11 and 0x22 → regs[9] = 0x11, and wr_conflict pulses for one cycle. Repeat with tag 0 → no write, no conflict.
- Scoreboard:
  - alloc tag 12 → rready = 0 next cycle.
  - Writeback 0x55 to tag 12 → rready = 1 and rdata = 0x55.
  - Simultaneous alloc and write of tag 12 → ready = 0, data = written value.
- Zero register: write 0x1234 to tag 0 and alloc tag 0 → reads of tag 0 stay 0 and rready stays 1.
- Reset mid-operation: assert reset_n low in the same cycle as a write to tag 3 → after release, regs[3] = 0 and ready[3] = 1.
